// File: rtl/ap9_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ap9_regfile_pkg
// Description : Shared widths, types and helpers for the register-file read
//               path (8 x 16-bit general registers r0..r7).
// Revision    : 1.0 - initial release
// ============================================================================
package ap9_regfile_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int SEL_W  = 4;

    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // The top select bit marks "no register"; only codes 0..7 name r0..r7.
    function automatic logic sel_in_range(input reg_sel_t sel);
        return !sel[SEL_W-1];
    endfunction

endpackage : ap9_regfile_pkg
`default_nettype wire

// File: rtl/register_read_stage_operand_select.sv
`default_nettype none
// ============================================================================
// Module      : operand_select
// Description : One read port of the register file. 8:1 register mux with a
//               zero result for out-of-range selects and a bypass of a write
//               landing on the same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_select
    import ap9_regfile_pkg::*;
(
    input  logic [NREG-1:0][DATA_W-1:0] i_regs,
    input  reg_sel_t                    i_sel,
    input  logic                        i_wr_en,
    input  reg_sel_t                    i_wr_sel,
    input  reg_data_t                   i_wr_data,
    output reg_data_t                   o_operand
);

    // Register files update on the same edge the operand is captured, so a
    // matching write must win over the (about to be stale) register value.
    always_comb begin
        o_operand = '0;
        if (sel_in_range(i_sel)) begin
            if (i_wr_en && (i_wr_sel == i_sel)) begin
                o_operand = i_wr_data;
            end else begin
                o_operand = i_regs[i_sel[SEL_W-2:0]];
            end
        end
    end

endmodule : operand_select
`default_nettype wire

// File: rtl/register_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : register_read_stage
// Description : Registered dual read port of the general register file with a
//               valid/ready handshake. Drives operand A on wireForM3 and
//               operand B on wireForM4. A held response tracks writes to the
//               registers it names, and stalled cycles are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module register_read_stage
    import ap9_regfile_pkg::*;
#(
    parameter int STALL_W = 8
) (
    input  logic               wire_clock,
    input  logic               wire_reset,
    input  reg_data_t          r0,
    input  reg_data_t          r1,
    input  reg_data_t          r2,
    input  reg_data_t          r3,
    input  reg_data_t          r4,
    input  reg_data_t          r5,
    input  reg_data_t          r6,
    input  reg_data_t          r7,
    input  logic               wr_en,
    input  reg_sel_t           wr_sel,
    input  reg_data_t          wr_data,
    input  logic               req_valid,
    output logic               req_ready,
    input  reg_sel_t           sel_a,
    input  reg_sel_t           sel_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output reg_data_t          wireForM3,
    output reg_data_t          wireForM4,
    output logic [STALL_W-1:0] stall_cnt
);

    // Held selects reset to the "no register" code so nothing snoops.
    localparam reg_sel_t           c_SEL_NONE  = reg_sel_t'({1'b1, {(SEL_W-1){1'b0}}});
    localparam logic [STALL_W-1:0] c_STALL_MAX = {STALL_W{1'b1}};

    logic                        r_rsp_valid;
    reg_data_t                   r_op_a;
    reg_data_t                   r_op_b;
    reg_sel_t                    r_held_sel_a;
    reg_sel_t                    r_held_sel_b;
    logic [STALL_W-1:0]          r_stall_cnt;

    logic [NREG-1:0][DATA_W-1:0] w_regs;
    reg_data_t                   w_op_a;
    reg_data_t                   w_op_b;
    logic                        w_req_ready;
    logic                        w_accept;
    logic                        w_hold;
    logic                        w_wr_valid;
    logic                        w_snoop_a;
    logic                        w_snoop_b;

    assign w_regs = {r7, r6, r5, r4, r3, r2, r1, r0};

    operand_select u_sel_a (
        .i_regs    (w_regs),
        .i_sel     (sel_a),
        .i_wr_en   (wr_en),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .o_operand (w_op_a)
    );

    operand_select u_sel_b (
        .i_regs    (w_regs),
        .i_sel     (sel_b),
        .i_wr_en   (wr_en),
        .i_wr_sel  (wr_sel),
        .i_wr_data (wr_data),
        .o_operand (w_op_b)
    );

    // Ready depends only on our own state and the consumer, never on req_valid.
    assign w_req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept    = req_valid && w_req_ready;
    assign w_hold      = r_rsp_valid && !rsp_ready;
    assign w_wr_valid  = wr_en && sel_in_range(wr_sel);
    assign w_snoop_a   = w_hold && w_wr_valid && (wr_sel == r_held_sel_a);
    assign w_snoop_b   = w_hold && w_wr_valid && (wr_sel == r_held_sel_b);

    // Response register: capture on accept, retire on drain, track writes while held.
    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            r_rsp_valid  <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_held_sel_a <= c_SEL_NONE;
            r_held_sel_b <= c_SEL_NONE;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_op_a       <= w_op_a;
            r_op_b       <= w_op_b;
            r_held_sel_a <= sel_a;
            r_held_sel_b <= sel_b;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_snoop_a) begin
                r_op_a <= wr_data;
            end
            if (w_snoop_b) begin
                r_op_b <= wr_data;
            end
        end
    end

    // Saturating count of cycles the consumer back-pressures a valid response.
    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            r_stall_cnt <= '0;
        end else if (w_hold && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign wireForM3 = r_op_a;
    assign wireForM4 = r_op_b;
    assign stall_cnt = r_stall_cnt;

endmodule : register_read_stage
`default_nettype wire

// File: tb/tb_register_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_read_stage
// Description : Scoreboard bench for register_read_stage. The stimulus side
//               owns an architectural register-file model and queues the
//               selects of every accepted request; the monitor compares each
//               presented response against the current architectural values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_read_stage;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } sel_pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rin [8];
    logic        we  = 1'b0;
    logic [3:0]  ws  = 4'h8;
    logic [15:0] wd  = 16'h0;
    logic        rv  = 1'b0;
    logic        rr  = 1'b1;
    logic [3:0]  sa  = 4'h8;
    logic [3:0]  sb  = 4'h8;

    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] wireForM3;
    logic [15:0] wireForM4;
    logic [7:0]  stall_cnt;

    // Reference model state
    logic [15:0] mregs [8];
    sel_pair_t   q [$];
    logic        pend      = 1'b0;
    int          stall     = 0;
    logic        zero_outs = 1'b1;
    logic        mon_en    = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    register_read_stage dut (
        .wire_clock (clk),
        .wire_reset (rst),
        .r0         (rin[0]),
        .r1         (rin[1]),
        .r2         (rin[2]),
        .r3         (rin[3]),
        .r4         (rin[4]),
        .r5         (rin[5]),
        .r6         (rin[6]),
        .r7         (rin[7]),
        .wr_en      (we),
        .wr_sel     (ws),
        .wr_data    (wd),
        .req_valid  (rv),
        .req_ready  (req_ready),
        .sel_a      (sa),
        .sel_b      (sb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rr),
        .wireForM3  (wireForM3),
        .wireForM4  (wireForM4),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An operand names an architectural register; out-of-range names read zero.
    function automatic logic [15:0] arch_val(input logic [3:0] sel);
        return sel[3] ? 16'h0000 : mregs[sel[2:0]];
    endfunction

    // Effect of one clock edge on the architectural model.
    task automatic model_edge();
        logic ready;
        logic acc;
        if (rst) begin
            pend      = 1'b0;
            stall     = 0;
            zero_outs = 1'b1;
            q.delete();
        end else begin
            if (pend && !rr && stall < 255) stall++;
            ready = !pend || rr;
            acc   = rv && ready;
            if (we && !ws[3]) mregs[ws[2:0]] = wd;
            if (acc) begin
                q.push_back('{a: sa, b: sb});
                zero_outs = 1'b0;
            end
            pend = acc || (pend && !rr);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic r, input logic w, input logic [3:0] s,
                        input logic [15:0] d);
        rv = v; sa = a; sb = b; rr = r; we = w; ws = s; wd = d;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 8; i++) rin[i] = mregs[i];
    endtask

    // Monitor: compare whatever the DUT presents against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(pend));
            chk("req_ready", 32'(req_ready), 32'(!pend || rr));
            chk("stall_cnt", 32'(stall_cnt), 32'(stall));
            if (zero_outs) begin
                chk("reset_M3", 32'(wireForM3), 32'h0);
                chk("reset_M4", 32'(wireForM4), 32'h0);
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_without_request", 32'(q.size()), 32'd1);
                end else begin
                    chk("M3", 32'(wireForM3), 32'(arch_val(q[0].a)));
                    chk("M4", 32'(wireForM4), 32'(arch_val(q[0].b)));
                end
            end
            if (pend && rr && q.size() > 0) void'(q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 16'h1111 * 16'(i + 1);
            rin[i]   = mregs[i];
        end

        // Reset
        rst = 1'b1;
        step(0, 4'h8, 4'h8, 1, 0, 4'h8, 16'h0);
        step(0, 4'h8, 4'h8, 1, 0, 4'h8, 16'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(0, 4'h8, 4'h8, 1, 0, 4'h8, 16'h0);

        // Basic read, then back-to-back requests
        step(1, 4'd2, 4'd7, 1, 0, 4'h8, 16'h0);
        chk("first_M3", 32'(wireForM3), 32'h3333);
        chk("first_M4", 32'(wireForM4), 32'h8888);
        step(1, 4'd0, 4'd1, 1, 0, 4'h8, 16'h0);
        step(1, 4'd6, 4'd6, 1, 0, 4'h8, 16'h0);
        step(1, 4'd4, 4'd9, 1, 0, 4'h8, 16'h0);
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);

        // Same-edge write bypass
        step(1, 4'd3, 4'd1, 1, 1, 4'd3, 16'hBEEF);
        chk("bypass_M3", 32'(wireForM3), 32'hBEEF);
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);

        // Long stall with a snooped write to the held B register
        step(1, 4'd0, 4'd5, 0, 0, 4'h8, 16'h0);
        for (int i = 0; i < 300; i++) begin
            if (i == 10) step(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 1, 4'd5, 16'hCAFE);
            else         step(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0, 4'h8, 16'h0);
        end
        chk("hold_M3", 32'(wireForM3), 32'h1111);
        chk("snoop_M4", 32'(wireForM4), 32'hCAFE);
        chk("hold_req_ready", 32'(req_ready), 32'h0);
        chk("stall_sat", 32'(stall_cnt), 32'hFF);
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);

        // Out-of-range selects and writes
        step(1, 4'hC, 4'h8, 1, 0, 4'h8, 16'h0);
        step(0, 4'd0, 4'd0, 0, 1, 4'hC, 16'h1234);
        chk("oor_M3", 32'(wireForM3), 32'h0);
        chk("oor_M4", 32'(wireForM4), 32'h0);
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);

        // Reset while a response is held
        step(1, 4'd1, 4'd2, 0, 0, 4'h8, 16'h0);
        step(0, 4'd0, 4'd0, 0, 0, 4'h8, 16'h0);
        rst = 1'b1;
        step(0, 4'd0, 4'd0, 0, 0, 4'h8, 16'h0);
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_M3", 32'(wireForM3), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0,
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 ($urandom % 3) != 0,
                 ($urandom % 2) != 0, 4'($urandom_range(0, 11)), 16'($urandom));
        end
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);
        step(0, 4'd0, 4'd0, 1, 0, 4'h8, 16'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_register_read_stage
`default_nettype wire
